mux_scan_ctrl: RTL and testbench

- Digital sequencer that drives the 2-bit select lines (S1,S0) of the analog 4:1 MUX front end and measures the comparator/latch output for each selected channel.
- For each channel it reports a duty count: the number of clock cycles the latch output was high during a programmable dwell window.
- Results leave on a valid/ready stream for downstream digital logic (register file or serial readout).
- Sits directly upstream of the MUX and downstream of the latch output.

---
 rtl/mux_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - 4:1 analog MUX scan sequencer with per-channel duty counting
// Defining MUX_SCAN_MASK_EN adds ch_mask[3:0] so that disabled channels are skipped.
module mux_scan_ctrl #(
   parameter int DWELL_W     = 8,
   parameter int SETTLE      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               comp_in,
`ifdef MUX_SCAN_MASK_EN
   input  logic [3:0]         ch_mask,
`endif
   output logic [1:0]         sel,
   output logic               latch_clr,
   output logic               busy,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [DWELL_W+1:0] res_data
);
   localparam int SW = $clog2(SETTLE + 1);

   typedef enum logic [2:0] {IDLE, SELECT, SETTLING, MEASURE, OUTPUT} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   comp_s;
   logic [1:0]             ch, ch_start, ch_adv;
   logic [DWELL_W-1:0]     dwell_q, count, meas_cnt;
   logic [SW-1:0]          settle_cnt;
   logic                   any_ch, settle_done, meas_done, handshake;

`ifdef MUX_SCAN_MASK_EN
   // First enabled channel at or after base, wrapping modulo 4.
   function automatic logic [1:0] next_enabled(input logic [1:0] base, input logic [3:0] mask);
      next_enabled = base;
      for (int i = 3; i >= 0; i--)
         if (mask[base + 2'(i)]) next_enabled = base + 2'(i);
   endfunction

   assign any_ch   = |ch_mask;
   assign ch_start = next_enabled(ch, ch_mask);
   assign ch_adv   = next_enabled(ch + 2'd1, ch_mask);
`else
   assign any_ch   = 1'b1;
   assign ch_start = ch;
   assign ch_adv   = ch + 2'd1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], comp_in};
   end
   assign comp_s = sync_q[SYNC_STAGES-1];

   assign settle_done = (settle_cnt == SW'(SETTLE - 1));
   assign meas_done   = (meas_cnt == dwell_q - DWELL_W'(1));
   assign handshake   = (state == OUTPUT) && res_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      latch_clr = 1'b0;
      busy      = 1'b1;
      res_valid = 1'b0;
      res_data  = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (en && any_ch) state_nxt = SELECT;
         end
         SELECT: begin
            latch_clr = 1'b1;
            state_nxt = SETTLING;
         end
         SETTLING:
            if (settle_done) state_nxt = (dwell_q == '0) ? OUTPUT : MEASURE;
         MEASURE:
            if (meas_done) state_nxt = OUTPUT;
         OUTPUT: begin
            res_valid = 1'b1;
            res_data  = {ch, count};
            if (res_ready) state_nxt = (en && any_ch) ? SELECT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // sel is loaded on entry to SELECT so it is already valid during the clear pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch         <= 2'd0;
         sel        <= 2'd0;
         dwell_q    <= '0;
         count      <= '0;
         meas_cnt   <= '0;
         settle_cnt <= '0;
      end else begin
         case (state)
            IDLE:
               if (state_nxt == SELECT) begin
                  ch  <= ch_start;
                  sel <= ch_start;
               end
            SELECT: begin
               dwell_q    <= dwell;
               count      <= '0;
               meas_cnt   <= '0;
               settle_cnt <= '0;
            end
            SETTLING:
               settle_cnt <= settle_cnt + SW'(1);
            MEASURE: begin
               count    <= count + DWELL_W'(comp_s);
               meas_cnt <= meas_cnt + DWELL_W'(1);
            end
            OUTPUT:
               if (handshake) begin
                  ch <= ch_adv;
                  if (state_nxt == SELECT) sel <= ch_adv;
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl
module tb_mux_scan_ctrl;
   localparam int DWELL_W     = 8;
   localparam int SETTLE      = 4;
   localparam int SYNC_STAGES = 2;
   localparam int MAXC        = 8192;
   localparam int BIG         = 32'h3fff_ffff;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b0;
   logic [DWELL_W-1:0] dwell = '0;
   logic               comp_in = 1'b0;
   logic               res_ready = 1'b0;
   logic [3:0]         mask_drv = 4'hF;
   logic [1:0]         sel;
   logic               latch_clr, busy, res_valid;
   logic [DWELL_W+1:0] res_data;

   always #5 clk = ~clk;

   mux_scan_ctrl #(.DWELL_W(DWELL_W), .SETTLE(SETTLE), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .dwell     (dwell),
      .comp_in   (comp_in),
`ifdef MUX_SCAN_MASK_EN
      .ch_mask   (mask_drv),
`endif
      .sel       (sel),
      .latch_clr (latch_clr),
      .busy      (busy),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data)
   );

   typedef struct {
      int dwell;
      int mode;      // 0: comp low, 1: comp high, 2: toggles every cycle
      int wait_n;    // cycles ready stays low after res_valid rises
      int exp_ch;
      int exp_cnt;
      int exp_len;   // cycles from latch_clr to handshake, inclusive
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   drv [MAXC];
   // schedule model: channel start cycle, result cycle, channel and count
   int   s_cyc, o_cyc, cnt_m;
   logic [1:0] ch_m, sel_m;
   bit   p_rst, p_en, p_rand;
   int   p_dwell, p_mode, p_wait;
   int   lc_cyc = 0, vr_cyc = 0;
   bit   prev_valid = 1'b0;
   bit   hs;
   logic [DWELL_W+1:0] hs_data;
   int   hs_len;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic logic [1:0] first_ch(input int base, input logic [3:0] m);
      for (int k = 0; k < 4; k++)
         if (m[(base + k) % 4]) return 2'((base + k) % 4);
      return 2'(base % 4);
   endfunction

   task automatic model_reset();
      s_cyc = -1;
      o_cyc = BIG;
      ch_m  = 2'd0;
      sel_m = 2'd0;
      cnt_m = 0;
   endtask

   task automatic step();
      logic exp_valid;
      @(negedge clk);
      cyc++;
      if (s_cyc >= 0 && cyc == o_cyc) begin
         cnt_m = 0;
         for (int k = s_cyc + 1 + SETTLE; k < o_cyc; k++) cnt_m += int'(drv[k - SYNC_STAGES]);
      end
      exp_valid = (s_cyc >= 0) && (cyc >= o_cyc);
      chk("busy", 32'(busy), 32'(s_cyc >= 0));
      chk("latch_clr", 32'(latch_clr), 32'(s_cyc >= 0 && cyc == s_cyc));
      chk("res_valid", 32'(res_valid), 32'(exp_valid));
      chk("sel", 32'(sel), 32'(sel_m));
      if (exp_valid) chk("res_data", 32'(res_data), (int'(ch_m) << DWELL_W) | cnt_m);
      if (latch_clr) lc_cyc = cyc;
      if (res_valid && !prev_valid) vr_cyc = cyc;
      prev_valid = res_valid;

      if (p_rst) begin
         rst = 1'b1; en = 1'b0; comp_in = 1'b0; res_ready = 1'b0;
      end else begin
         rst = 1'b0;
         if (p_rand) begin
            en        = ($urandom_range(0, 15) != 0);
            dwell     = DWELL_W'($urandom_range(0, 12));
            comp_in   = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_SCAN_MASK_EN
            if ($urandom_range(0, 31) == 0) mask_drv = 4'($urandom_range(0, 15));
`endif
         end else begin
            en    = p_en;
            dwell = DWELL_W'(p_dwell);
            case (p_mode)
               0:       comp_in = 1'b0;
               1:       comp_in = 1'b1;
               default: comp_in = cyc[0];
            endcase
            res_ready = res_valid ? (cyc - vr_cyc >= p_wait) : 1'b1;
         end
      end
      if (cyc < MAXC) drv[cyc] = comp_in;
      hs = res_valid && res_ready && !rst;
      if (hs) begin
         hs_data = res_data;
         hs_len  = cyc - lc_cyc + 1;
      end

      if (rst) model_reset();
      else if (s_cyc < 0) begin
         if (en && mask_drv != 4'd0) begin
            ch_m  = first_ch(int'(ch_m), mask_drv);
            sel_m = ch_m;
            s_cyc = cyc + 1;
            o_cyc = BIG;
         end
      end else begin
         if (cyc == s_cyc) o_cyc = s_cyc + 1 + SETTLE + int'(dwell);
         if (cyc >= o_cyc && res_ready) begin
            ch_m = first_ch(int'(ch_m) + 1, mask_drv);
            if (en && mask_drv != 4'd0) begin
               sel_m = ch_m;
               s_cyc = cyc + 1;
               o_cyc = BIG;
            end else begin
               s_cyc = -1;
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [11];
      int   n;
      tbl[0]  = '{10, 1, 0,  0, 10, 16};
      tbl[1]  = '{10, 1, 0,  1, 10, 16};
      tbl[2]  = '{10, 1, 0,  2, 10, 16};
      tbl[3]  = '{10, 1, 0,  3, 10, 16};
      tbl[4]  = '{10, 1, 0,  0, 10, 16};
      tbl[5]  = '{8,  2, 0,  1, 4,  14};
      tbl[6]  = '{8,  2, 20, 2, 4,  34};
      tbl[7]  = '{0,  1, 0,  3, 0,  6};
      tbl[8]  = '{255,1, 0,  0, 255,261};
      tbl[9]  = '{1,  0, 0,  1, 0,  7};
      tbl[10] = '{1,  1, 3,  2, 1,  10};

      model_reset();
      p_rst = 1'b1; p_en = 1'b1; p_rand = 1'b0;
      p_dwell = 10; p_mode = 1; p_wait = 0;
      repeat (3) step();
      chk("reset_res_data", 32'(res_data), 32'd0);
      p_rst = 1'b0;

      for (int r = 0; r < 11; r++) begin
         p_dwell = tbl[r].dwell;
         p_mode  = tbl[r].mode;
         p_wait  = tbl[r].wait_n;
         n = 0;
         hs = 1'b0;
         while (!hs && n < 400) begin step(); n++; end
         chk($sformatf("row%0d_done", r), 32'(hs), 32'd1);
         chk($sformatf("row%0d_ch", r), 32'(hs_data[DWELL_W+1:DWELL_W]), tbl[r].exp_ch);
         chk($sformatf("row%0d_cnt", r), 32'(hs_data[DWELL_W-1:0]), tbl[r].exp_cnt);
         chk($sformatf("row%0d_len", r), hs_len, tbl[r].exp_len);
      end

      // drop enable in the middle of channel 1's measurement window
      p_dwell = 6; p_mode = 1; p_wait = 0;
      n = 0;
      while (!(s_cyc >= 0 && ch_m == 2'd1 && cyc == s_cyc + 3 + SETTLE) && n < 200) begin
         step(); n++;
      end
      chk("reach_ch1_measure", 32'(busy), 32'd1);
      p_en = 1'b0;
      n = 0;
      hs = 1'b0;
      while (!hs && n < 50) begin step(); n++; end
      chk("drop_en_delivered", 32'(hs), 32'd1);
      chk("drop_en_ch", 32'(hs_data[DWELL_W+1:DWELL_W]), 32'd1);
      chk("drop_en_cnt", 32'(hs_data[DWELL_W-1:0]), 32'd6);
      repeat (3) step();
      chk("drop_en_idle", 32'(busy), 32'd0);
      p_en = 1'b1;
      n = 0;
      do begin step(); n++; end while (!latch_clr && n < 10);
      chk("resume_select", 32'(latch_clr), 32'd1);
      chk("resume_sel", 32'(sel), 32'd2);
      repeat (SETTLE + 3) step();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_latch_clr", 32'(latch_clr), 32'd0);
      chk("async_rst_res_valid", 32'(res_valid), 32'd0);
      chk("async_rst_sel", 32'(sel), 32'd0);
      chk("async_rst_res_data", 32'(res_data), 32'd0);
      model_reset();
      p_rst = 1'b1;
      repeat (3) step();
      p_rst = 1'b0;

      p_rand = 1'b1;
      repeat (1500) step();
      p_rand = 1'b0;

`ifdef MUX_SCAN_MASK_EN
      p_rst = 1'b1;
      repeat (3) step();
      p_rst = 1'b0;
      mask_drv = 4'b1010;
      p_en = 1'b1; p_dwell = 3; p_mode = 1; p_wait = 0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         hs = 1'b0;
         while (!hs && n < 100) begin step(); n++; end
         chk($sformatf("mask_ch%0d", i), 32'(hs_data[DWELL_W+1:DWELL_W]), (i % 2 == 0) ? 32'd1 : 32'd3);
      end
      mask_drv = 4'b0000;
      n = 0;
      while (busy && n < 50) begin step(); n++; end
      repeat (20) begin
         step();
         chk("mask0_busy", 32'(busy), 32'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
